det_share_ctrl: RTL and testbench
=================================

DET_SHARE_CTRL -- requirements
Module: det_share_ctrl

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the bits per word (legal range 2..16).
REQ-002 clk  in  1  clock; all state changes occur on its rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 req  in  4  per-requester request, level, held until the matching ack.
REQ-005 req_data  in  4*WIDTH  flattened words; requester i uses bits [i*WIDTH +: WIDTH].
REQ-006 ack  out  4  one-hot, one-cycle completion pulse to the granted requester.
REQ-007 result  out  WIDTH  detector z response word, valid while ack is nonzero.
REQ-008 gnt_id  out  2  index of the requester currently being served.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 det_x  out  1  registered serial bit to the shared detector x input.
REQ-011 det_rst_n  out  1  registered active-low clear to the shared detector reset_n.
REQ-012 det_z  in  1  registered detector output z.

Function
REQ-013 The block SHALL share one serial Mealy detector among 4 requesters using states IDLE, CLEAR, SHIFT, DRAIN and DONE.
REQ-014 In IDLE with any req bit set, the block SHALL grant the first set bit at or after rr_ptr (wrapping 3->0), latch that word and gnt_id, and enter CLEAR.
REQ-015 In IDLE with req == 0, the block SHALL remain in IDLE.
REQ-016 det_rst_n SHALL be 0 for exactly the one CLEAR cycle and 1 in all other states.
REQ-017 SHIFT SHALL last exactly WIDTH cycles and drive det_x with the latched word MSB first, one bit per cycle.
REQ-018 The z response to bit k SHALL be sampled from det_z in the cycle after bit k is driven, and stored at result bit position WIDTH-1-k.
REQ-019 DRAIN SHALL last one cycle, capture the response to the last bit, and then enter DONE.
REQ-020 DONE SHALL last one cycle, with ack[gnt_id]=1 and result valid; rr_ptr SHALL then become (gnt_id+1) mod 4, and the next state SHALL be IDLE.
REQ-021 Latency from the IDLE cycle that samples req to the ack cycle SHALL be WIDTH+3 cycles (11 for WIDTH=8).
REQ-022 Deasserting req or changing req_data after grant SHALL NOT affect the transaction in progress; it completes and ack still pulses.
REQ-023 Requests arriving while busy SHALL wait and be arbitrated only in IDLE; with all four asserted continuously, grants SHALL be issued in order 0,1,2,3,0.
REQ-024 det_x SHALL be 0 outside SHIFT.
REQ-025 result SHALL hold its last value outside DONE.
REQ-026 ack SHALL be 0 outside DONE.
REQ-027 An internal bit counter SHALL count from 0 to WIDTH-1 with no wrap beyond it.

Reset
REQ-028 While reset_n=0, the state SHALL be IDLE and rr_ptr, gnt_id, result, ack, busy, det_x and det_rst_n SHALL all be 0, so the detector is held in its reset state.
REQ-029 A reset asserted mid-transaction SHALL abort it with no ack.
REQ-030 After reset release, the block SHALL resume arbitration from requester 0 in the first IDLE cycle.

Verification
REQ-031 req=4'b0001 with word 8'hFF -> det_rst_n low for 1 cycle; 8 SHIFT cycles; ack=4'b0001 11 cycles after sampling; result=8'hFF.
REQ-032 req0 with word 8'h00 -> result=8'h80. req0 with word 8'hAA -> result=8'hAA. req0 with word 8'h55 -> result=8'hD5.
REQ-033 req=4'b1111 held with distinct words -> acks in order 0,1,2,3, each 12 cycles apart, and each result matches its own word.
REQ-034 After serving requester 2, assert req=4'b0101 -> requester 0 granted first, then requester 2.
REQ-035 Drop req0 during SHIFT -> transaction completes and ack[0] still pulses; a mid-SHIFT reset_n pulse -> no ack, all outputs 0, and the next request gets a normal full-latency response.

Source files
------------

// File: rtl/det_share_ctrl.sv
// det_share_ctrl
// Time-shares one external serial Mealy detector among four requesters.
// A requester's word is granted round-robin. The controller clears the
// detector and streams the word into it MSB first. It collects the
// detector's registered z answer for every bit. Then it hands the collected
// word back with a one-cycle ack.
//
// Ports
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   req        [3:0] level requests, held until the matching ack
//   req_data   [4*WIDTH-1:0] one word per requester, requester i at [i*WIDTH +: WIDTH]
//   ack        [3:0] one-hot completion pulse, one cycle, in DONE only
//   result     [WIDTH-1:0] collected z word, valid with ack, held otherwise
//   gnt_id     [1:0] requester currently being served
//   busy       high whenever the controller is not IDLE
//   det_x      registered serial bit to the detector
//   det_rst_n  registered active-low clear to the detector
//   det_z      registered z output of the detector
module det_share_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   req_data,
    output logic [3:0]           ack,
    output logic [WIDTH-1:0]     result,
    output logic [1:0]           gnt_id,
    output logic                 busy,
    output logic                 det_x,
    output logic                 det_rst_n,
    input  logic                 det_z
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [1:0]         rr_ptr_reg;
    logic [1:0]         gnt_id_reg;
    logic [WIDTH-1:0]   word_reg;
    logic [CNT_W-1:0]   bit_cnt_reg;
    logic [WIDTH-2:0]   z_sh_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               det_x_reg;
    logic               det_rst_n_reg;

    // Unflattened request words.
    logic [WIDTH-1:0]   words [4];

    // Round-robin pick.
    logic               pick_valid;
    logic [1:0]         pick_id;
    logic [1:0]         cand;

    // The z answers collected so far plus the one arriving this cycle.
    logic [WIDTH-1:0]   z_cat;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_req
            assign words[gi] = req_data[gi*WIDTH +: WIDTH];
            assign ack[gi]   = (state_reg == DONE) && (gnt_id_reg == 2'(gi));
        end
    endgenerate

    // Scan from farthest to nearest so the first set bit at or after
    // rr_ptr is the last one written.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = rr_ptr_reg;
        cand       = '0;
        for (int i = 3; i >= 0; i--) begin
            cand = rr_ptr_reg + 2'(i);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pick_valid) state_next = CLEAR;
            CLEAR:   state_next = SHIFT;
            SHIFT:   if (bit_cnt_reg == LAST_BIT) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign z_cat = {z_sh_reg, det_z};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            gnt_id_reg    <= '0;
            word_reg      <= '0;
            bit_cnt_reg   <= '0;
            z_sh_reg      <= '0;
            result_reg    <= '0;
            det_x_reg     <= 1'b0;
            det_rst_n_reg <= 1'b0;
        end else begin
            state_reg <= state_next;

            // Both detector-facing outputs are computed from the next state.
            // This makes the registered values line up with the state they
            // belong to.
            det_rst_n_reg <= (state_next != CLEAR);

            if (state_reg == IDLE && pick_valid) begin
                word_reg   <= words[pick_id];
                gnt_id_reg <= pick_id;
            end else if (state_next == SHIFT) begin
                word_reg <= {word_reg[WIDTH-2:0], 1'b0};
            end

            if (state_next == SHIFT) begin
                det_x_reg <= word_reg[WIDTH-1];
            end else begin
                det_x_reg <= 1'b0;
            end

            // Bit counter saturates at the last bit; cleared outside SHIFT.
            if (state_reg == SHIFT) begin
                if (bit_cnt_reg != LAST_BIT) begin
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                end
            end else begin
                bit_cnt_reg <= '0;
            end

            // det_z lags det_x by one cycle. In the first SHIFT cycle no
            // answer is pending yet. The last answer arrives in DRAIN.
            if (state_reg == SHIFT && bit_cnt_reg != '0) begin
                z_sh_reg <= z_cat[WIDTH-2:0];
            end
            if (state_reg == DRAIN) begin
                result_reg <= z_cat;
            end

            if (state_reg == DONE) begin
                rr_ptr_reg <= gnt_id_reg + 2'd1;
            end
        end
    end

    assign result    = result_reg;
    assign gnt_id    = gnt_id_reg;
    assign busy      = (state_reg != IDLE);
    assign det_x     = det_x_reg;
    assign det_rst_n = det_rst_n_reg;

endmodule

// File: tb/tb_det_share_ctrl.sv
// Bench for det_share_ctrl.
// The bench contains a stand-in detector. After a clear, its first bit
// answers 1. After that it echoes x. Its z output is registered. Expected
// results are pushed to a scoreboard when a request is driven. They are
// checked by a monitor whenever ack fires.
module tb_det_share_ctrl;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [3:0]     req;
    logic [4*W-1:0] req_data;
    logic [3:0]     ack;
    logic [W-1:0]   result;
    logic [1:0]     gnt_id;
    logic           busy;
    logic           det_x;
    logic           det_rst_n;
    logic           det_z;

    det_share_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .result    (result),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .det_x     (det_x),
        .det_rst_n (det_rst_n),
        .det_z     (det_z)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in detector
    logic det_seen;
    always @(posedge clk or negedge det_rst_n) begin
        if (!det_rst_n) begin
            det_z    <= 1'b0;
            det_seen <= 1'b0;
        end else begin
            det_z    <= det_x | ~det_seen;
            det_seen <= 1'b1;
        end
    end

    typedef struct {
        logic [3:0]   ack;
        logic [W-1:0] res;
        int           at;
        int           id;
    } exp_t;

    typedef struct {
        int           id;
        logic [W-1:0] word;
        logic [W-1:0] res;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ack(input int id, input logic [W-1:0] res, input int at);
        exp_t e;
        e.ack = 4'(1 << id);
        e.res = res;
        e.at  = at;
        e.id  = id;
        sb.push_back(e);
    endtask

    task automatic set_word(input int id, input logic [W-1:0] w);
        req_data[id*W +: W] = w;
    endtask

    // Wait until every expected ack has been seen (bounded), then drop req.
    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            check({name, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    // Monitor: one line per completed transaction
    always @(negedge clk) begin
        if (ack != 4'b0000) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", int'(ack), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_onehot", int'(ack), int'(e.ack));
                check("result", int'(result), int'(e.res));
                check("gnt_id", int'(gnt_id), e.id);
                check("ack_cycle", cyc, e.at);
                $display("txn: id=%0d result=0x%02h cycle=%0d", gnt_id, result, cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[7];
    int   n;

    initial begin
        vecs[0] = '{0, 8'hFF, 8'hFF};
        vecs[1] = '{0, 8'h00, 8'h80};
        vecs[2] = '{0, 8'hAA, 8'hAA};
        vecs[3] = '{0, 8'h55, 8'hD5};
        vecs[4] = '{1, 8'h3C, 8'hBC};
        vecs[5] = '{2, 8'h01, 8'h81};
        vecs[6] = '{3, 8'h80, 8'h80};

        reset_n  = 1'b0;
        req      = 4'b0000;
        req_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", int'(ack), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_det_x", int'(det_x), 0);
        check("rst_det_rst_n", int'(det_rst_n), 0);
        check("rst_gnt_id", int'(gnt_id), 0);
        check("rst_result", int'(result), 0);

        reset_n = 1'b1;
        @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_det_rst_n", int'(det_rst_n), 1);

        // Clear pulse, SHIFT window and latency for a single 0xFF request
        n = cyc;
        set_word(0, 8'hFF);
        req = 4'b0001;
        expect_ack(0, 8'hFF, n + 11);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            check("clear_pulse", int'(det_rst_n), (c == 1) ? 0 : 1);
            check("shift_det_x", int'(det_x), (c >= 2 && c <= 9) ? 1 : 0);
            check("busy_during", int'(busy), 1);
        end
        wait_done("ff_seq");
        check("busy_after", int'(busy), 0);

        // Single requests from the table
        for (int i = 0; i < 7; i++) begin
            n = cyc;
            set_word(vecs[i].id, vecs[i].word);
            req = 4'(1 << vecs[i].id);
            expect_ack(vecs[i].id, vecs[i].res, n + 11);
            wait_done("table");
            check("result_hold", int'(result), int'(vecs[i].res));
            check("ack_idle", int'(ack), 0);
        end

        // All four requesting continuously
        set_word(0, 8'h12);
        set_word(1, 8'h34);
        set_word(2, 8'h56);
        set_word(3, 8'h78);
        n = cyc;
        req = 4'b1111;
        expect_ack(0, 8'h92, n + 11);
        expect_ack(1, 8'hB4, n + 23);
        expect_ack(2, 8'hD6, n + 35);
        expect_ack(3, 8'hF8, n + 47);
        wait_done("all_four");

        // Serve 2, then 0101 must grant 0 before 2
        n = cyc;
        set_word(2, 8'h0F);
        req = 4'b0100;
        expect_ack(2, 8'h8F, n + 11);
        wait_done("serve2");
        set_word(0, 8'hE1);
        set_word(2, 8'h7E);
        n = cyc;
        req = 4'b0101;
        expect_ack(0, 8'hE1, n + 11);
        expect_ack(2, 8'hFE, n + 23);
        wait_done("rr_wrap");

        // Drop req0 and scramble data mid-SHIFT
        n = cyc;
        set_word(0, 8'hC3);
        req = 4'b0001;
        expect_ack(0, 8'hC3, n + 11);
        repeat (4) @(negedge clk);
        req      = 4'b0000;
        req_data = '0;
        wait_done("drop");

        // Move rr_ptr to 3 so a reset-cleared pointer is observable
        n = cyc;
        set_word(2, 8'h44);
        req = 4'b0100;
        expect_ack(2, 8'hC4, n + 11);
        wait_done("rr_to_3");

        // Reset in the middle of SHIFT aborts with no ack
        set_word(3, 8'h5A);
        req = 4'b1000;
        repeat (5) @(negedge clk);
        check("mid_busy", int'(busy), 1);
        reset_n = 1'b0;
        req     = 4'b0000;
        #1;
        check("abort_ack", int'(ack), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_det_x", int'(det_x), 0);
        check("abort_det_rst_n", int'(det_rst_n), 0);
        check("abort_gnt_id", int'(gnt_id), 0);
        check("abort_result", int'(result), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", int'(busy), 0);

        // After reset arbitration restarts at 0: 1010 grants 1 then 3
        set_word(1, 8'h21);
        set_word(3, 8'h9C);
        n = cyc;
        req = 4'b1010;
        expect_ack(1, 8'hA1, n + 11);
        expect_ack(3, 8'h9C, n + 23);
        wait_done("post_reset");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
